// File: rtl/aes_key_schedule_seq.sv
`default_nettype none

// ============================================================================
// Module      : aes_sbox
// Description : AES forward S-box, single byte lookup from a constant table.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 sits in the most significant byte, so entry x lives at bit
    // 8*(255-x)+7 downwards, which is simply {~x, 3'b111}.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[{~i_byte, 3'b111} -: 8];

endmodule

// ============================================================================
// Module      : aes_key_schedule_seq
// Description : Sequential AES-128/192/256 key expansion, one 32-bit word
//               per cycle, streaming 128-bit round keys over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_idx,
    output logic                done
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] c_LAST_WORD = 6'(NW - 1);
    localparam logic [5:0] c_NK_WORDS  = 6'(NK);
    localparam logic [2:0] c_KPOS_LAST = 3'(NK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    // Sliding window of the last NK words; r_win[0] is the oldest (w[i-NK]).
    logic [31:0]   r_win [0:NK-1];
    logic [95:0]   r_acc;          // first three words of the current group
    logic [5:0]    r_word_cnt;     // index i of the next word to produce
    logic [2:0]    r_kpos;         // i mod NK
    logic [7:0]    r_rcon;
    logic          r_rk_valid;
    logic [127:0]  r_rk_data;
    logic [3:0]    r_rk_idx;
    logic          r_done;

    logic          w_load;
    logic          w_stall;
    logic          w_produce;
    logic          w_xfer;
    logic          w_last;
    logic          w_key_phase;
    logic [31:0]   w_prev;
    logic [31:0]   w_sub_in;
    logic [31:0]   w_sub;
    logic [31:0]   w_temp;
    logic [31:0]   w_new;

    assign w_load      = (r_state == ST_IDLE) && start;
    assign w_stall     = r_rk_valid && !rk_ready;
    assign w_produce   = (r_state == ST_GEN) && !w_stall;
    assign w_xfer      = r_rk_valid && rk_ready;
    assign w_last      = (r_word_cnt == c_LAST_WORD);
    assign w_key_phase = (r_word_cnt < c_NK_WORDS);

    assign w_prev   = r_win[NK-1];
    assign w_sub_in = (r_kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    // One word of SubWord: four byte lookups in parallel.
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_sub_in[8*b +: 8]),
            .o_byte (w_sub[8*b +: 8])
        );
    end

    // Word rule: key words pass straight through (the window rotates them
    // out and back in), later words combine w[i-NK] with a transformed w[i-1].
    always_comb begin
        w_temp = w_prev;
        if (r_kpos == 3'd0) begin
            w_temp = w_sub ^ {r_rcon, 24'h000000};
        end else if ((NK == 8) && (r_kpos == 3'd4)) begin
            w_temp = w_sub;
        end
        w_new = w_key_phase ? r_win[0] : (r_win[0] ^ w_temp);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: generate all words, then wait for the last handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)              w_state_next = ST_GEN;
            ST_GEN:   if (w_produce && w_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_xfer)              w_state_next = ST_IDLE;
            default:                           w_state_next = ST_IDLE;
        endcase
    end

    // Word generation, round-key assembly and output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NK; j++) begin
                r_win[j] <= 32'h0;
            end
            r_acc      <= 96'h0;
            r_word_cnt <= 6'd0;
            r_kpos     <= 3'd0;
            r_rcon     <= 8'h01;
            r_rk_valid <= 1'b0;
            r_rk_data  <= 128'h0;
            r_rk_idx   <= 4'd0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_load) begin
                for (int j = 0; j < NK; j++) begin
                    r_win[j] <= key_in[KEY_BITS-1-32*j -: 32];
                end
                r_word_cnt <= 6'd0;
                r_kpos     <= 3'd0;
                r_rcon     <= 8'h01;
            end else if (w_produce) begin
                for (int j = 0; j < NK-1; j++) begin
                    r_win[j] <= r_win[j+1];
                end
                r_win[NK-1] <= w_new;
                r_acc       <= {r_acc[63:0], w_new};
                if (!w_last) begin
                    r_word_cnt <= r_word_cnt + 6'd1;
                end
                r_kpos <= (r_kpos == c_KPOS_LAST) ? 3'd0 : r_kpos + 3'd1;
                if (!w_key_phase && (r_kpos == 3'd0)) begin
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                end
            end

            // A completing group may load on the same edge as a transfer.
            if (w_produce && (r_word_cnt[1:0] == 2'b11)) begin
                r_rk_data  <= {r_acc, w_new};
                r_rk_idx   <= r_word_cnt[5:2];
                r_rk_valid <= 1'b1;
            end else if (w_xfer) begin
                r_rk_valid <= 1'b0;
            end

            if ((r_state == ST_DRAIN) && w_xfer) begin
                r_done <= 1'b1;
            end
        end
    end

    // Only the three AES key lengths are meaningful.
    always_ff @(posedge clk) begin
        assert (KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)
            else $error("aes_key_schedule_seq: illegal KEY_BITS %0d", KEY_BITS);
    end

    assign busy     = (r_state != ST_IDLE);
    assign rk_valid = r_rk_valid;
    assign rk_data  = r_rk_data;
    assign rk_idx   = r_rk_idx;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule_seq.sv
`default_nettype none
`timescale 1ns/1ps

// ============================================================================
// Module      : tb_aes_key_schedule_seq
// Description : Self-checking bench for aes_key_schedule_seq, all three key
//               lengths, against an array-based key-expansion model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule_seq;

    localparam logic [127:0] c_KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] c_KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] c_KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         rk_ready;
    logic [255:0] key_bus;
    int           sel;

    logic         start_a, start_b, start_c;
    logic         busy_a, busy_b, busy_c;
    logic         valid_a, valid_b, valid_c;
    logic         done_a, done_b, done_c;
    logic [127:0] data_a, data_b, data_c;
    logic [3:0]   idx_a, idx_b, idx_c;

    logic         mon_busy, mon_valid, mon_done;
    logic [127:0] mon_data;
    logic [3:0]   mon_idx;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_rk   [0:14];
    logic [127:0] obs_rk   [0:14];

    always #5 clk = ~clk;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    aes_key_schedule_seq #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .key_in(key_bus[255:128]),
        .busy(busy_a), .rk_valid(valid_a), .rk_ready(rk_ready),
        .rk_data(data_a), .rk_idx(idx_a), .done(done_a)
    );

    aes_key_schedule_seq #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .key_in(key_bus[255:64]),
        .busy(busy_b), .rk_valid(valid_b), .rk_ready(rk_ready),
        .rk_data(data_b), .rk_idx(idx_b), .done(done_b)
    );

    aes_key_schedule_seq #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .start(start_c), .key_in(key_bus),
        .busy(busy_c), .rk_valid(valid_c), .rk_ready(rk_ready),
        .rk_data(data_c), .rk_idx(idx_c), .done(done_c)
    );

    // Route the selected instance onto a common monitor.
    always_comb begin
        mon_busy  = busy_a;
        mon_valid = valid_a;
        mon_done  = done_a;
        mon_data  = data_a;
        mon_idx   = idx_a;
        case (sel)
            1: begin
                mon_busy = busy_b; mon_valid = valid_b; mon_done = done_b;
                mon_data = data_b; mon_idx = idx_b;
            end
            2: begin
                mon_busy = busy_c; mon_valid = valid_c; mon_done = done_c;
                mon_data = data_c; mon_idx = idx_c;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        logic       hi;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
            y  = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic init_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    endfunction

    // Full expansion into an array, then grouped into round keys.
    task automatic build_expected(input int nk, input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nk + 6; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One expansion: s selects key size (0/1/2), stall_pct drives random
    // backpressure, tamper pokes start/key_in mid-run, abort_round >= 0
    // resets the block when that round key is presented.
    task automatic run_expansion(input int s, input logic [255:0] key, input int stall_pct,
                                 input bit tamper, input int abort_round);
        int nk, nr, nw, edge_n, got, stalls, cyc, first_valid;
        logic         hold;
        logic [127:0] held_data;
        logic [3:0]   held_idx;
        nk = 4 + 2 * s;
        nr = nk + 6;
        nw = 4 * (nr + 1);
        sel = s;
        key_bus = key;
        build_expected(nk, key);
        @(negedge clk);
        start = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk);
        edge_n = 0;
        #1;
        chk("busy_after_start", 128'(mon_busy), 128'd1);
        got = 0; stalls = 0; cyc = 0; hold = 1'b0; first_valid = -1;
        held_data = '0; held_idx = '0;
        while (got <= nr && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = tamper && (cyc == 10);
            if (tamper && cyc == 10) key_bus = rand_key();
            rk_ready = ($urandom_range(0, 99) >= stall_pct);
            if (abort_round >= 0 && mon_valid && int'(mon_idx) == abort_round) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", 128'(mon_valid), 128'd0);
                chk("rst_busy",  128'(mon_busy),  128'd0);
                chk("rst_done",  128'(mon_done),  128'd0);
                chk("rst_data",  mon_data,        128'd0);
                chk("rst_idx",   128'(mon_idx),   128'd0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                rk_ready = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                chk("no_rk_after_rst", 128'(mon_valid), 128'd0);
                return;
            end
            if (mon_valid) begin
                if (first_valid < 0) begin
                    first_valid = edge_n;
                    chk("latency_rk0", 128'(edge_n), 128'd4);
                end
                if (hold) begin
                    chk("stall_data_stable", mon_data, held_data);
                    chk("stall_idx_stable", 128'(mon_idx), 128'(held_idx));
                end
                if (rk_ready) begin
                    chk("rk_data", mon_data, exp_rk[got]);
                    chk("rk_idx", 128'(mon_idx), 128'(got));
                    obs_rk[got] = mon_data;
                    got++;
                    hold = 1'b0;
                end else begin
                    stalls++;
                    hold = 1'b1;
                    held_data = mon_data;
                    held_idx = mon_idx;
                end
            end
            @(posedge clk);
            edge_n++;
        end
        start = 1'b0;
        chk("rk_count", 128'(got), 128'(nr + 1));
        #1;
        chk("done_pulse", 128'(mon_done), 128'd1);
        chk("done_edge", 128'(edge_n), 128'(nw + 1 + stalls));
        @(posedge clk);
        #1;
        chk("done_clear", 128'(mon_done), 128'd0);
        chk("busy_clear", 128'(mon_busy), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k;
        rst_n = 1'b0;
        start = 1'b0;
        rk_ready = 1'b1;
        key_bus = '0;
        sel = 0;
        init_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  128'(mon_busy),  128'd0);
        chk("reset_valid", 128'(mon_valid), 128'd0);
        chk("reset_done",  128'(mon_done),  128'd0);
        chk("reset_data",  mon_data,        128'd0);
        chk("reset_idx",   128'(mon_idx),   128'd0);
        chk("reset_busy256", 128'(busy_c),  128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors, no backpressure.
        run_expansion(0, {c_KEY128, 128'h0}, 0, 1'b0, -1);
        chk("kat128_rk0",  obs_rk[0],  c_KEY128);
        chk("kat128_rk1",  obs_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("kat128_rk10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_expansion(1, {c_KEY192, 64'h0}, 0, 1'b0, -1);
        chk("kat192_rk12", obs_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        run_expansion(2, c_KEY256, 0, 1'b0, -1);
        chk("kat256_rk14", obs_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Backpressure on the AES-128 vector.
        run_expansion(0, {c_KEY128, 128'h0}, 50, 1'b0, -1);
        chk("bp128_rk1",  obs_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
        chk("bp128_rk10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start and key_in poked while busy must not disturb the run.
        run_expansion(0, {c_KEY128, 128'h0}, 0, 1'b1, -1);
        chk("tamper_rk10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset during round 5, then a clean restart.
        run_expansion(0, {c_KEY128, 128'h0}, 0, 1'b0, 5);
        run_expansion(0, {c_KEY128, 128'h0}, 0, 1'b0, -1);
        chk("restart_rk0",  obs_rk[0],  c_KEY128);
        chk("restart_rk10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Random keys on every size, with and without backpressure.
        for (int n = 0; n < 9; n++) begin
            k = rand_key();
            if (n % 3 == 0) k[127:0] = '0;
            if (n % 3 == 1) k[63:0] = '0;
            run_expansion(n % 3, k, (n < 3) ? 0 : 40, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
